// File: rtl/fib_pkg.sv
// Shared Fibonacci definitions: checker state encoding and the default width/seeds used by
// both the generators and the checker, so their sequences line up by construction.
package fib_pkg;

    typedef enum logic [1:0] {
        StRun,
        StFail,
        StDone
    } state_t;

    localparam int unsigned FIB_W     = 16;
    localparam int unsigned FIB_SEED0 = 1;
    localparam int unsigned FIB_SEED1 = 1;

endpackage

// File: rtl/fib_next_calc.sv
// Combinational Fibonacci stepper: from the current pair (exp0, exp1) produce the pair one
// term ahead and the pair two terms ahead, all modulo 2^W.
module fib_next_calc #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_exp0,
    input  logic [W-1:0] i_exp1,
    output logic [W-1:0] o_single0,
    output logic [W-1:0] o_single1,
    output logic [W-1:0] o_double0,
    output logic [W-1:0] o_double1
);

    logic [W-1:0] w_sum;

    assign w_sum     = i_exp0 + i_exp1;
    assign o_single0 = i_exp1;
    assign o_single1 = w_sum;
    assign o_double0 = w_sum;
    assign o_double1 = w_sum + i_exp1;

endmodule

// File: rtl/fibonacci_stream_checker.sv
// Sink-side Fibonacci checker: compares one or two terms per beat against a tracked sequence
// and keeps pass/fail status, a matched-term count and first-failure diagnostics.
module fibonacci_stream_checker
    import fib_pkg::*;
#(
    parameter int unsigned W       = FIB_W,
    parameter int unsigned SEED0   = FIB_SEED0,
    parameter int unsigned SEED1   = FIB_SEED1,
    parameter int unsigned N_TERMS = 24,
    localparam int unsigned CW     = $clog2(N_TERMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          in_valid,
    input  logic          in_pair,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          ok,
    output logic          fail,
    output logic          done,
    output logic [CW-1:0] term_cnt,
    output logic [CW-1:0] err_idx,
    output logic [W-1:0]  err_got,
    output logic [W-1:0]  err_exp
);

    localparam logic [W-1:0]  LP_SEED0 = W'(SEED0);
    localparam logic [W-1:0]  LP_SEED1 = W'(SEED1);
    localparam logic [CW-1:0] LP_N     = CW'(N_TERMS);
    localparam logic [CW-1:0] LP_LAST  = CW'(N_TERMS - 1);

    state_t        r_state;
    logic [W-1:0]  r_exp0, r_exp1;
    logic          r_ok, r_fail, r_done;
    logic [CW-1:0] r_term_cnt, r_err_idx;
    logic [W-1:0]  r_err_got, r_err_exp;

    logic [W-1:0]  w_single0, w_single1, w_double0, w_double1;
    logic          w_a_match, w_b_match, w_last;
    logic [CW-1:0] w_cnt_p1, w_cnt_p2;

    fib_next_calc #(
        .W (W)
    ) u_next (
        .i_exp0    (r_exp0),
        .i_exp1    (r_exp1),
        .o_single0 (w_single0),
        .o_single1 (w_single1),
        .o_double0 (w_double0),
        .o_double1 (w_double1)
    );

    assign w_a_match = (in_a == r_exp0);
    assign w_b_match = (in_b == r_exp1);
    assign w_last    = (r_term_cnt == LP_LAST);
    assign w_cnt_p1  = r_term_cnt + CW'(1);
    assign w_cnt_p2  = r_term_cnt + CW'(2);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state    <= StRun;
            r_exp0     <= LP_SEED0;
            r_exp1     <= LP_SEED1;
            r_ok       <= 1'b1;
            r_fail     <= 1'b0;
            r_done     <= 1'b0;
            r_term_cnt <= '0;
            r_err_idx  <= '0;
            r_err_got  <= '0;
            r_err_exp  <= '0;
        end else if (r_state == StRun && in_valid) begin
            if (!w_a_match) begin
                r_state   <= StFail;
                r_ok      <= 1'b0;
                r_fail    <= 1'b1;
                r_err_idx <= r_term_cnt;
                r_err_got <= in_a;
                r_err_exp <= r_exp0;
            end else if (!in_pair || w_last) begin
                // Lane b is ignored on the final term so the count cannot overshoot N_TERMS.
                r_exp0     <= w_single0;
                r_exp1     <= w_single1;
                r_term_cnt <= w_cnt_p1;
                if (w_cnt_p1 == LP_N) begin
                    r_state <= StDone;
                    r_done  <= 1'b1;
                end
            end else if (!w_b_match) begin
                r_term_cnt <= w_cnt_p1;
                r_state    <= StFail;
                r_ok       <= 1'b0;
                r_fail     <= 1'b1;
                r_err_idx  <= w_cnt_p1;
                r_err_got  <= in_b;
                r_err_exp  <= r_exp1;
            end else begin
                r_exp0     <= w_double0;
                r_exp1     <= w_double1;
                r_term_cnt <= w_cnt_p2;
                if (w_cnt_p2 == LP_N) begin
                    r_state <= StDone;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign ok       = r_ok;
    assign fail     = r_fail;
    assign done     = r_done;
    assign term_cnt = r_term_cnt;
    assign err_idx  = r_err_idx;
    assign err_got  = r_err_got;
    assign err_exp  = r_err_exp;

endmodule

// File: tb/tb_fibonacci_stream_checker.sv
// Scoreboard bench: the driver queues the expected post-beat outputs, per-DUT monitors pop
// and compare after each clock edge that carried a beat, reset or restart.
module tb_fibonacci_stream_checker;

    typedef struct packed {
        logic        ok;
        logic        fail;
        logic        done;
        logic [4:0]  cnt;
        logic [4:0]  idx;
        logic [15:0] got;
        logic [15:0] exp;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N_TERMS=24, DUT B: N_TERMS=30
    logic        a_rst = 0, a_restart = 0, a_valid = 0, a_pair = 0;
    logic [15:0] a_in_a = 0, a_in_b = 0;
    logic        a_ok, a_fail, a_done;
    logic [4:0]  a_cnt, a_idx;
    logic [15:0] a_got, a_exp;

    logic        b_rst = 0, b_restart = 0, b_valid = 0, b_pair = 0;
    logic [15:0] b_in_a = 0, b_in_b = 0;
    logic        b_ok, b_fail, b_done;
    logic [4:0]  b_cnt, b_idx;
    logic [15:0] b_got, b_exp;

    fibonacci_stream_checker #(.N_TERMS(24)) u_dut_a (
        .clk      (clk),
        .rst      (a_rst),
        .restart  (a_restart),
        .in_valid (a_valid),
        .in_pair  (a_pair),
        .in_a     (a_in_a),
        .in_b     (a_in_b),
        .ok       (a_ok),
        .fail     (a_fail),
        .done     (a_done),
        .term_cnt (a_cnt),
        .err_idx  (a_idx),
        .err_got  (a_got),
        .err_exp  (a_exp)
    );

    fibonacci_stream_checker #(.N_TERMS(30)) u_dut_b (
        .clk      (clk),
        .rst      (b_rst),
        .restart  (b_restart),
        .in_valid (b_valid),
        .in_pair  (b_pair),
        .in_a     (b_in_a),
        .in_b     (b_in_b),
        .ok       (b_ok),
        .fail     (b_fail),
        .done     (b_done),
        .term_cnt (b_cnt),
        .err_idx  (b_idx),
        .err_got  (b_got),
        .err_exp  (b_exp)
    );

    obs_t q_a[$];
    obs_t q_b[$];
    int   total = 0;
    int   bad   = 0;
    logic issued_a = 0, issued_b = 0;
    logic [15:0] fib [0:29];

    function automatic obs_t mk(input bit ok, input bit fl, input bit dn, input int cnt,
                                input int idx, input int got, input int ex);
        obs_t o;
        o.ok   = ok;
        o.fail = fl;
        o.done = dn;
        o.cnt  = 5'(cnt);
        o.idx  = 5'(idx);
        o.got  = 16'(got);
        o.exp  = 16'(ex);
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got ok=%0b fail=%0b done=%0b cnt=%0d idx=%0d got=%0d exp=%0d; want ok=%0b fail=%0b done=%0b cnt=%0d idx=%0d got=%0d exp=%0d",
                     name, act.ok, act.fail, act.done, act.cnt, act.idx, act.got, act.exp,
                     want.ok, want.fail, want.done, want.cnt, want.idx, want.got, want.exp);
        end
    endtask

    always @(posedge clk) begin
        issued_a <= a_rst | a_restart | a_valid;
        issued_b <= b_rst | b_restart | b_valid;
    end

    always @(negedge clk) begin
        if (issued_a) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut24_queue: got empty scoreboard, want pending entry");
            end else begin
                compare("dut24", {a_ok, a_fail, a_done, a_cnt, a_idx, a_got, a_exp},
                        q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (issued_b) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut30_queue: got empty scoreboard, want pending entry");
            end else begin
                compare("dut30", {b_ok, b_fail, b_done, b_cnt, b_idx, b_got, b_exp},
                        q_b.pop_front());
            end
        end
    end

    // One cycle of stimulus on the selected DUT; the expected outputs go on its queue.
    task automatic drive(input bit sel, input bit rs, input bit rsr, input bit v, input bit p,
                         input int a, input int b, input obs_t e);
        if (!sel) begin
            a_rst = rs; a_restart = rsr; a_valid = v; a_pair = p;
            a_in_a = 16'(a); a_in_b = 16'(b);
            q_a.push_back(e);
        end else begin
            b_rst = rs; b_restart = rsr; b_valid = v; b_pair = p;
            b_in_a = 16'(a); b_in_b = 16'(b);
            q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        a_rst = 0; a_restart = 0; a_valid = 0; a_pair = 0;
        b_rst = 0; b_restart = 0; b_valid = 0; b_pair = 0;
    endtask

    initial begin
        obs_t rst_val;
        fib = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55,
                16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987, 16'd1597, 16'd2584,
                16'd4181, 16'd6765, 16'd10946, 16'd17711, 16'd28657, 16'd46368, 16'd9489,
                16'd55857, 16'd65346, 16'd55667, 16'd55477, 16'd45608};
        rst_val = mk(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // ---- DUT A ----
        drive(0, 1, 0, 0, 0, 0, 0, rst_val);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0, fib[i], 0, mk(1, 0, 0, i + 1, 0, 0, 0));

        drive(0, 0, 1, 0, 0, 0, 0, rst_val);
        drive(0, 0, 0, 1, 1, 1, 1, mk(1, 0, 0, 2, 0, 0, 0));
        drive(0, 0, 0, 1, 1, 2, 3, mk(1, 0, 0, 4, 0, 0, 0));
        drive(0, 0, 0, 1, 1, 5, 8, mk(1, 0, 0, 6, 0, 0, 0));
        drive(0, 0, 0, 1, 1, 13, 21, mk(1, 0, 0, 8, 0, 0, 0));
        drive(0, 0, 0, 1, 1, 34, 55, mk(1, 0, 0, 10, 0, 0, 0));

        drive(0, 0, 1, 0, 0, 0, 0, rst_val);
        drive(0, 0, 0, 1, 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 1, 0, mk(1, 0, 0, 2, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 2, 0, mk(1, 0, 0, 3, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 4, 0, mk(0, 1, 0, 3, 3, 4, 3));
        drive(0, 0, 0, 1, 0, 5, 0, mk(0, 1, 0, 3, 3, 4, 3));

        drive(0, 0, 1, 0, 0, 0, 0, rst_val);
        drive(0, 0, 0, 1, 1, 1, 1, mk(1, 0, 0, 2, 0, 0, 0));
        drive(0, 0, 0, 1, 1, 2, 9, mk(0, 1, 0, 3, 3, 9, 3));

        drive(0, 0, 1, 0, 0, 0, 0, rst_val);
        drive(0, 0, 0, 1, 1, 7, 2, mk(0, 1, 0, 0, 0, 7, 1));

        // Completion boundary: reach 23, then a pair whose lane b must be ignored.
        drive(0, 0, 1, 0, 0, 0, 0, rst_val);
        for (int k = 0; k < 11; k++)
            drive(0, 0, 0, 1, 1, fib[2*k], fib[2*k+1], mk(1, 0, 0, 2*k + 2, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 28657, 0, mk(1, 0, 0, 23, 0, 0, 0));
        drive(0, 0, 0, 1, 1, 46368, 0, mk(1, 0, 1, 24, 0, 0, 0));
        drive(0, 0, 0, 1, 1, 9489, 55857, mk(1, 0, 1, 24, 0, 0, 0));
        drive(0, 0, 0, 1, 0, 123, 0, mk(1, 0, 1, 24, 0, 0, 0));
        drive(0, 0, 1, 1, 0, 1, 0, rst_val);
        drive(0, 0, 0, 1, 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0));

        // ---- DUT B: wrap-around and mid-stream reset ----
        drive(1, 1, 0, 0, 0, 0, 0, rst_val);
        for (int i = 0; i < 30; i++)
            drive(1, 0, 0, 1, 0, fib[i], 0, mk(1, 0, (i == 29), i + 1, 0, 0, 0));
        drive(1, 0, 0, 1, 0, 7, 0, mk(1, 0, 1, 30, 0, 0, 0));
        drive(1, 1, 0, 0, 0, 0, 0, rst_val);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 1, 0, fib[i], 0, mk(1, 0, 0, i + 1, 0, 0, 0));
        drive(1, 1, 0, 1, 0, fib[10], 0, rst_val);
        drive(1, 0, 0, 1, 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0));
        drive(1, 0, 0, 1, 0, 1, 0, mk(1, 0, 0, 2, 0, 0, 0));
        drive(1, 0, 0, 1, 0, 2, 0, mk(1, 0, 0, 3, 0, 0, 0));

        repeat (3) @(posedge clk);
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
